// File: rtl/vga_tile_controller.sv
// rtl/vga_tile_controller.sv - parametrised VGA tile-grid display controller
module vga_tile_controller #(
    parameter int          H_ACTIVE   = 640,
    parameter int          H_FP       = 16,
    parameter int          H_SYNC     = 96,
    parameter int          H_BP       = 48,
    parameter int          V_ACTIVE   = 480,
    parameter int          V_FP       = 10,
    parameter int          V_SYNC     = 2,
    parameter int          V_BP       = 33,
    parameter int          CELL_W     = 10,
    parameter int          CELL_H     = 10,
    parameter int          GRID_W     = 64,
    parameter int          GRID_H     = 48,
    parameter int          IDX_W      = 4,
    parameter int          ADDR_W     = 12,
    parameter logic [23:0] BORDER_RGB = 24'h000000
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              tile_we,
    input  logic [ADDR_W-1:0] tile_waddr,
    input  logic [IDX_W-1:0]  tile_wdata,
    input  logic              pal_we,
    input  logic [IDX_W-1:0]  pal_idx,
    input  logic [23:0]       pal_wdata,
    input  logic              cursor_en,
    input  logic [7:0]        cursor_x,
    input  logic [7:0]        cursor_y,
    output logic              oHS,
    output logic              oVS,
    output logic              oBLANK_n,
    output logic [7:0]        b_data,
    output logic [7:0]        g_data,
    output logic [7:0]        r_data,
    output logic              frame_start
);

    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int CELLS      = GRID_W * GRID_H;
    localparam int PAL_DEPTH  = 2 ** IDX_W;
    localparam int TILE_DEPTH = 2 ** ADDR_W;
    localparam int CW         = 16;

    // Stage 0: raster and cell counters
    logic [CW-1:0] hc, vc, px, cx, py, cy, row_base;
    logic          end_line, end_frame;

    // Stage 0 decode
    logic              active0, hs0_n, vs0_n, in_grid0, cursor_hit0, frame0;
    logic [ADDR_W-1:0] tile_raddr;

    // Stage 1 registers
    logic              s1_active, s1_hs_n, s1_vs_n, s1_in_grid, s1_cursor, s1_frame;
    logic [IDX_W-1:0]  tile_q;

    // Storage
    logic [IDX_W-1:0]  tile_mem [0:TILE_DEPTH-1];
    logic [23:0]       pal [0:PAL_DEPTH-1];
    logic [23:0]       colour;

    assign end_line  = (hc == CW'(H_TOTAL - 1));
    assign end_frame = end_line && (vc == CW'(V_TOTAL - 1));

    // Raster position plus incremental cell position; row_base tracks cy*GRID_W
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            hc       <= '0;
            vc       <= '0;
            px       <= '0;
            cx       <= '0;
            py       <= '0;
            cy       <= '0;
            row_base <= '0;
        end else begin
            if (end_line) begin
                hc <= '0;
                vc <= end_frame ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end

            if (end_line) begin
                px <= '0;
                cx <= '0;
            end else if (active0) begin
                if (px == CW'(CELL_W - 1)) begin
                    px <= '0;
                    cx <= cx + 1'b1;
                end else begin
                    px <= px + 1'b1;
                end
            end

            if (end_frame) begin
                py       <= '0;
                cy       <= '0;
                row_base <= '0;
            end else if (end_line && (vc < CW'(V_ACTIVE))) begin
                if (py == CW'(CELL_H - 1)) begin
                    py       <= '0;
                    cy       <= cy + 1'b1;
                    row_base <= row_base + CW'(GRID_W);
                end else begin
                    py <= py + 1'b1;
                end
            end
        end
    end

    // Stage 0 decode of sync, blanking, grid membership and cursor hit
    always_comb begin
        active0     = (hc < CW'(H_ACTIVE)) && (vc < CW'(V_ACTIVE));
        hs0_n       = !((hc >= CW'(H_ACTIVE + H_FP)) && (hc < CW'(H_ACTIVE + H_FP + H_SYNC)));
        vs0_n       = !((vc >= CW'(V_ACTIVE + V_FP)) && (vc < CW'(V_ACTIVE + V_FP + V_SYNC)));
        in_grid0    = (cx < CW'(GRID_W)) && (cy < CW'(GRID_H));
        cursor_hit0 = cursor_en && (cx == CW'(cursor_x)) && (cy == CW'(cursor_y));
        frame0      = (hc == '0) && (vc == '0);
        tile_raddr  = ADDR_W'(row_base + cx);
    end

    // Tile RAM: write-gated to the grid, read-before-write, never reset
    always_ff @(posedge iVGA_CLK) begin
        if (tile_we && (32'(tile_waddr) < 32'(CELLS)))
            tile_mem[tile_waddr] <= tile_wdata;
        tile_q <= tile_mem[tile_raddr];
    end

    // Stage 1 control pipeline, flushed to blank on reset
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            s1_active  <= 1'b0;
            s1_hs_n    <= 1'b1;
            s1_vs_n    <= 1'b1;
            s1_in_grid <= 1'b0;
            s1_cursor  <= 1'b0;
            s1_frame   <= 1'b0;
        end else begin
            s1_active  <= active0;
            s1_hs_n    <= hs0_n;
            s1_vs_n    <= vs0_n;
            s1_in_grid <= in_grid0;
            s1_cursor  <= cursor_hit0;
            s1_frame   <= frame0;
        end
    end

    // Palette registers, cleared on reset
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            for (int i = 0; i < PAL_DEPTH; i++)
                pal[i] <= '0;
        end else if (pal_we) begin
            pal[pal_idx] <= pal_wdata;
        end
    end

    // Stage 2 colour select: blank, border, inverted cursor cell, palette
    always_comb begin
        colour = '0;
        if (!s1_active)
            colour = '0;
        else if (!s1_in_grid)
            colour = BORDER_RGB;
        else if (s1_cursor)
            colour = ~pal[tile_q];
        else
            colour = pal[tile_q];
    end

    // Stage 2 output register
    always_ff @(posedge iVGA_CLK) begin
        if (!iRST_n) begin
            oHS         <= 1'b1;
            oVS         <= 1'b1;
            oBLANK_n    <= 1'b0;
            b_data      <= '0;
            g_data      <= '0;
            r_data      <= '0;
            frame_start <= 1'b0;
        end else begin
            oHS         <= s1_hs_n;
            oVS         <= s1_vs_n;
            oBLANK_n    <= s1_active;
            b_data      <= colour[23:16];
            g_data      <= colour[15:8];
            r_data      <= colour[7:0];
            frame_start <= s1_frame;
        end
    end

endmodule

// File: tb/tb_vga_tile_controller.sv
// tb/tb_vga_tile_controller.sv - directed self-checking bench for vga_tile_controller
module tb_vga_tile_controller;

    localparam int HT    = 56;
    localparam int VT    = 37;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BORDER = 24'h0A0B0C;

    logic       clk = 1'b0;
    logic       iRST_n;
    logic       tile_we;
    logic [5:0] tile_waddr;
    logic [3:0] tile_wdata;
    logic       pal_we;
    logic [3:0] pal_idx;
    logic [23:0] pal_wdata;
    logic       cursor_en;
    logic [7:0] cursor_x, cursor_y;
    logic       oHS, oVS, oBLANK_n, frame_start;
    logic [7:0] b_data, g_data, r_data;
    logic [23:0] rgb;

    int tests = 0;
    int fails = 0;
    int pos   = 0;

    assign rgb = {b_data, g_data, r_data};

    always #5 clk = ~clk;

    vga_tile_controller #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .CELL_W(4), .CELL_H(3), .GRID_W(8), .GRID_H(7),
        .IDX_W(4), .ADDR_W(6), .BORDER_RGB(BORDER)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(iRST_n),
        .tile_we(tile_we), .tile_waddr(tile_waddr), .tile_wdata(tile_wdata),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_wdata(pal_wdata),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n),
        .b_data(b_data), .g_data(g_data), .r_data(r_data),
        .frame_start(frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % FRAME;
    endtask

    task automatic goto(input int x, input int y);
        int tgt;
        int guard;
        tgt   = y * HT + x;
        guard = 0;
        while (pos != tgt && guard <= FRAME) begin
            step();
            guard++;
        end
    endtask

    task automatic wr_tile(input logic [5:0] a, input logic [3:0] d);
        tile_we = 1'b1; tile_waddr = a; tile_wdata = d;
        step();
        tile_we = 1'b0;
    endtask

    task automatic wr_pal(input logic [3:0] i, input logic [23:0] d);
        pal_we = 1'b1; pal_idx = i; pal_wdata = d;
        step();
        pal_we = 1'b0;
    endtask

    task automatic chk_pix(input string tag, input int x, input int y, input logic [23:0] exp);
        goto(x, y);
        check(tag, {8'h00, rgb}, {8'h00, exp});
    endtask

    initial begin
        int x, y, bad, bl_cnt, hs_cnt, vs_cnt;
        logic exp_bl, exp_hs, exp_vs;

        iRST_n = 1'b0; tile_we = 1'b0; tile_waddr = '0; tile_wdata = '0;
        pal_we = 1'b0; pal_idx = '0; pal_wdata = '0;
        cursor_en = 1'b0; cursor_x = '0; cursor_y = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hs", {31'd0, oHS}, 32'd1);
        check("rst_vs", {31'd0, oVS}, 32'd1);
        check("rst_blank", {31'd0, oBLANK_n}, 32'd0);
        check("rst_rgb", {8'h00, rgb}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);

        for (int a = 0; a < 56; a++)
            wr_tile(6'(a), 4'd0);

        iRST_n = 1'b1;
        @(posedge clk); #1;
        check("fs_edge1", {31'd0, frame_start}, 32'd0);
        @(posedge clk); #1;
        check("fs_edge2", {31'd0, frame_start}, 32'd1);
        check("first_active", {31'd0, oBLANK_n}, 32'd1);
        check("pal_reset_rgb", {8'h00, rgb}, 32'd0);
        pos = 0;

        bad = 0; bl_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int n = 0; n < FRAME; n++) begin
            x = n % HT;
            y = n / HT;
            exp_bl = (x < 40) && (y < 30);
            exp_hs = !((x >= 44) && (x < 50));
            exp_vs = !((y >= 32) && (y < 34));
            if (oBLANK_n !== exp_bl || oHS !== exp_hs || oVS !== exp_vs ||
                frame_start !== (n == 0))
                bad++;
            if (!exp_bl && rgb !== 24'h0)
                bad++;
            if (oBLANK_n) bl_cnt++;
            if (!oHS) hs_cnt++;
            if (!oVS) vs_cnt++;
            step();
        end
        check("timing_pattern", 32'(bad), 32'd0);
        check("blank_count", 32'(bl_cnt), 32'd1200);
        check("hs_low_count", 32'(hs_cnt), 32'd222);
        check("vs_low_count", 32'(vs_cnt), 32'd112);
        check("frame_period", {31'd0, frame_start}, 32'd1);

        wr_pal(4'd0, 24'h111111);
        wr_pal(4'd3, 24'h00FF00);
        wr_pal(4'd5, 24'h102030);
        wr_tile(6'd9, 4'd3);
        wr_tile(6'd2, 4'd5);
        wr_tile(6'd60, 4'd7);
        goto(0, 25);

        chk_pix("tile2_plain", 8, 0, 24'h102030);
        chk_pix("border_right", 32, 0, BORDER);
        chk_pix("blank_rgb", 45, 0, 24'h000000);
        check("blank_flag", {31'd0, oBLANK_n}, 32'd0);
        chk_pix("cell0_edge", 3, 3, 24'h111111);
        chk_pix("cell9_first", 4, 3, 24'h00FF00);
        chk_pix("cell10_first", 8, 3, 24'h111111);
        chk_pix("cell9_last", 7, 5, 24'h00FF00);
        chk_pix("cell17_first", 4, 6, 24'h111111);
        chk_pix("grid_last", 31, 20, 24'h111111);
        chk_pix("border_bottom", 0, 21, BORDER);
        chk_pix("border_corner", 39, 29, BORDER);

        goto(0, 25);
        cursor_en = 1'b1; cursor_x = 8'd2; cursor_y = 8'd0;
        chk_pix("cur_left_nb", 7, 0, 24'h111111);
        chk_pix("cur_first", 8, 0, 24'hEFDFCF);
        chk_pix("cur_right_nb", 12, 0, 24'h111111);
        chk_pix("cur_last", 11, 2, 24'hEFDFCF);
        chk_pix("cur_below_nb", 8, 3, 24'h111111);

        goto(0, 25);
        cursor_x = 8'd8;
        chk_pix("cur_oob_cell", 8, 0, 24'h102030);
        chk_pix("cur_oob_border", 32, 0, BORDER);
        goto(0, 25);
        cursor_en = 1'b0;

        goto(0, 0);
        pal_we = 1'b1; pal_idx = 4'd0; pal_wdata = 24'h222222;
        step();
        check("pal_wr_old", {8'h00, rgb}, 32'h00111111);
        pal_we = 1'b0;
        step();
        check("pal_wr_new", {8'h00, rgb}, 32'h00222222);
        wr_pal(4'd0, 24'h111111);

        goto(10, 0);
        tile_we = 1'b1; tile_waddr = 6'd3; tile_wdata = 4'd3;
        step();
        tile_we = 1'b0;
        step();
        check("rw_same_old", {8'h00, rgb}, 32'h00111111);
        step();
        check("rw_after_new", {8'h00, rgb}, 32'h0000FF00);
        chk_pix("oob_write_cell0", 0, 0, 24'h111111);
        chk_pix("rw_next_frame", 12, 0, 24'h00FF00);
        chk_pix("oob_write_cell7", 28, 0, 24'h111111);

        goto(18, 10);
        check("pre_reset_active", {31'd0, oBLANK_n}, 32'd1);
        iRST_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_hs", {31'd0, oHS}, 32'd1);
        check("mid_rst_vs", {31'd0, oVS}, 32'd1);
        check("mid_rst_blank", {31'd0, oBLANK_n}, 32'd0);
        check("mid_rst_rgb", {8'h00, rgb}, 32'd0);
        check("mid_rst_fs", {31'd0, frame_start}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        iRST_n = 1'b1;
        @(posedge clk); #1;
        check("rel_fs_edge1", {31'd0, frame_start}, 32'd0);
        @(posedge clk); #1;
        check("rel_fs_edge2", {31'd0, frame_start}, 32'd1);
        pos = 0;
        wr_pal(4'd0, 24'h111111);
        wr_pal(4'd3, 24'h00FF00);
        chk_pix("kept_cell3", 12, 0, 24'h00FF00);
        chk_pix("kept_cell0", 3, 3, 24'h111111);
        chk_pix("kept_cell9", 4, 3, 24'h00FF00);
        chk_pix("kept_border", 0, 21, BORDER);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
